gray_conv_pipe: RTL and testbench

Parametrised, pipelined binary/Gray code engine with valid/ready flow control. It generalises the team's fixed 4-bit combinational binary-to-Gray converter in three ways: it handles any width, it converts in both directions, and it contains a loadable Gray-sequence counter. Each beat selects its own mode. The block sits between a streaming producer and consumer, typically on the path of multi-bit counter values that must cross clock domains or be decoded after crossing.

---
 rtl/gray_pkg.sv | 30 +++
 rtl/pipe_reg.sv | 30 +++
 rtl/gray_conv_pipe.sv | 100 ++++++++++
 tb/tb_gray_conv_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray conversion pipeline: beat modes and
// width-generic code conversion helpers.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_B2G   = 2'b00,
    MODE_G2B   = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam int unsigned GRAY_MAX_W = 64;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Operands are zero-extended into the wide word; leading zeros do not
  // disturb either conversion, so callers simply truncate the result.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic single-entry valid/ready register stage; accepts whenever it is
// empty or its content is leaving in the same cycle.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Two-stage binary/Gray conversion engine with a loadable Gray-sequence
// counter; mode decode and counter live here, staging is in pipe_reg.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_wrap
);

  localparam int unsigned PW = WIDTH + 3;

  logic [WIDTH-1:0] cnt;
  mode_e            mode;
  logic             accept;
  logic [WIDTH-1:0] operand;
  logic             wrap;
  logic [PW-1:0]    a_in, a_q, b_in, b_q;
  logic             a_valid, b_ready;
  logic [1:0]       a_mode;
  logic [WIDTH-1:0] a_op, a_res;
  logic             a_wrap;

  assign accept = in_valid && in_ready;

  // COUNT snapshots cnt at accept time so backpressure cannot reorder values.
  always_comb begin
    mode    = mode_e'(in_mode);
    operand = in_data;
    wrap    = 1'b0;
    if (mode == MODE_COUNT) begin
      operand = cnt;
      wrap    = (cnt == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      if (mode == MODE_COUNT) begin
        cnt <= cnt + WIDTH'(1);
      end else if (mode == MODE_LOAD) begin
        cnt <= in_data + WIDTH'(1);
      end
    end
  end

  assign a_in = {in_mode, operand, wrap};

  pipe_reg #(.W(PW)) u_stage_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (a_in),
    .out_valid (a_valid),
    .out_ready (b_ready),
    .out_data  (a_q)
  );

  assign a_mode = a_q[PW-1 -: 2];
  assign a_op   = a_q[WIDTH:1];
  assign a_wrap = a_q[0];

  always_comb begin
    a_res = WIDTH'(bin2gray(gray_word_t'(a_op)));
    if (mode_e'(a_mode) == MODE_G2B) begin
      a_res = WIDTH'(gray2bin(gray_word_t'(a_op)));
    end
  end

  assign b_in = {a_mode, a_res, a_wrap};

  pipe_reg #(.W(PW)) u_stage_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .in_ready  (b_ready),
    .in_data   (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (b_q)
  );

  assign out_mode = b_q[PW-1 -: 2];
  assign out_data = b_q[WIDTH:1];
  assign out_wrap = b_q[0];

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Scoreboard bench for gray_conv_pipe (WIDTH=4) with directed vectors.
module tb_gray_conv_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_mode = 2'b00;
  logic [3:0] in_data = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic [1:0] out_mode;
  logic       out_wrap;

  typedef struct {
    logic [3:0] data;
    logic [1:0] mode;
    logic       wrap;
    int         acc_cyc;
    bit         chk_lat;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   accepts = 0;
  bit   chk_lat_en = 1'b1;

  gray_conv_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_wrap  (out_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, pops on every transfer, checks stall stability.
  initial begin : monitor
    exp_t       e;
    bit         prev_stall;
    logic [6:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_payload", {25'd0, out_mode, out_wrap, out_data}, {25'd0, prev_word});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got data %b mode %b wrap %b expected none",
                   out_data, out_mode, out_wrap);
        end else begin
          e = q.pop_front();
          check("out_data", {28'd0, out_data}, {28'd0, e.data});
          check("out_mode", {30'd0, out_mode}, {30'd0, e.mode});
          check("out_wrap", {31'd0, out_wrap}, {31'd0, e.wrap});
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_mode, out_wrap, out_data};
    end
  end

  task automatic send(input logic [1:0] m, input logic [3:0] d,
                      input logic [3:0] ed, input logic ew);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    #1;
    while (!in_ready) begin
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.data    = ed;
    e.mode    = m;
    e.wrap    = ew;
    e.acc_cyc = cyc;
    e.chk_lat = chk_lat_en;
    q.push_back(e);
    accepts++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] b2g_in  [4] = '{4'b1001, 4'b0011, 4'b1111, 4'b0101};
  logic [3:0] b2g_out [4] = '{4'b1101, 4'b0010, 4'b1000, 4'b0111};
  logic [3:0] cnt_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [3:0] st_in  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b0110};
  logic [3:0] st_out [6] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1111, 4'b0101};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_out_mode", {30'd0, out_mode}, 32'd0);
    check("rst_out_wrap", {31'd0, out_wrap}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: B2G stream, 2: G2B stream
    for (int i = 0; i < 4; i++) send(2'b00, b2g_in[i], b2g_out[i], 1'b0);
    for (int i = 0; i < 4; i++) send(2'b01, b2g_out[i], b2g_in[i], 1'b0);
    idle();
    drain();

    // 3: counter sequence with wrap
    reset_pulse();
    for (int i = 0; i < 17; i++) send(2'b10, 4'b1010, cnt_seq[i], (i == 15));
    idle();
    drain();

    // 4: LOAD then COUNT continues the sequence
    send(2'b11, 4'b1110, 4'b1001, 1'b0);
    send(2'b10, 4'b0000, 4'b1000, 1'b1);
    send(2'b10, 4'b0000, 4'b0000, 1'b0);
    idle();
    drain();

    // 5: backpressure stall
    chk_lat_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    accepts   = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'b00, st_in[i], st_out[i], 1'b0);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        #2;
        check("stall_accepts", accepts, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // 6: reset with two beats in flight, cnt = 0101
    out_ready = 1'b0;
    send(2'b11, 4'b0100, 4'b0110, 1'b0);
    send(2'b00, 4'b0011, 4'b0010, 1'b0);
    idle();
    #2;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_lat_en = 1'b1;
    send(2'b10, 4'b0000, 4'b0000, 1'b0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
